divider_signed: RTL and testbench
=================================

DIVIDER_SIGNED -- requirements
Module: divider_signed

Interface
REQ-001 SHALL have parameter DW, default 12, meaning dividend and quotient width (two's complement).
REQ-002 SHALL have parameter VW, default 4, meaning divisor and remainder width (two's complement); VW < DW.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, request to begin a division with the current y and b.
REQ-006 SHALL have port y, input, DW, signed dividend.
REQ-007 SHALL have port b, input, VW, signed divisor.
REQ-008 SHALL have port busy, output, 1, high while a division is in progress.
REQ-009 SHALL have port done, output, 1, single-cycle pulse when q/r/flags become valid.
REQ-010 SHALL have port q, output, DW, signed quotient.
REQ-011 SHALL have port r, output, VW, signed remainder.
REQ-012 SHALL have port div_zero, output, 1, set with done when b was 0.
REQ-013 SHALL have port ovf, output, 1, set with done when the true quotient is not representable in DW bits.

Function
REQ-014 SHALL implement an FSM with states IDLE, CALC, FIX, DONE.
REQ-015 SHALL accept a request only in IDLE or DONE when start=1: register y and b, clear div_zero/ovf, assert busy from the next cycle.
REQ-016 SHALL ignore start while busy=1; captured operands stay unchanged.
REQ-017 SHALL, on accept with b!=0, enter CALC and run exactly DW restoring shift-subtract iterations on operand magnitudes, one bit per cycle, MSB first.
REQ-018 SHALL, after the last CALC cycle, spend one FIX cycle applying signs: q negated if sign(y)!=sign(b); r negated if y<0.
REQ-019 SHALL give truncating division: q rounded toward zero, r with the sign of y or zero, |r| < |b|, y == q*b + r.
REQ-020 SHALL assert done for exactly one cycle on entry to DONE; latency from the accepting edge to the done-high edge is DW+2 cycles (14 at default).
REQ-021 SHALL hold q, r, div_zero and ovf stable from done until the next accepted start.
REQ-022 SHALL, on accept with b==0, skip CALC/FIX and enter DONE next cycle with q=all ones (-1), r=0, div_zero=1 (latency 1).
REQ-023 SHALL, for y = -2^(DW-1) and b = -1, return q = -2^(DW-1) (wrapped), r=0, ovf=1, latency DW+2.
REQ-024 SHALL compute magnitudes in DW+1 bits internally so |-2^(DW-1)| and |-2^(VW-1)| are exact.
REQ-025 SHALL drop busy in the same cycle done rises; busy=0 in IDLE and DONE.
REQ-026 SHALL allow back-to-back operation: start during the done cycle is accepted and begins a new division next cycle.

Reset
REQ-027 SHALL, while reset_n=0, force state IDLE, busy=0, done=0, q=0, r=0, div_zero=0, ovf=0, independent of clock.
REQ-028 SHALL abort any in-progress division on reset; no done is produced for it after release.
REQ-029 SHALL accept a start on the first rising edge after reset_n deasserts.

Verification
REQ-030 SHALL cover y=-10, b=5 -> after 14 cycles done=1, q=-2, r=0, flags 0; and y=6, b=3 -> q=2, r=0.
REQ-031 SHALL cover sign rules: y=7,b=-2 -> q=-3,r=1; y=-7,b=2 -> q=-3,r=-1; y=-7,b=-2 -> q=3,r=-1; y=35,b=-7 -> q=-5,r=0.
REQ-032 SHALL cover y=100, b=0 -> done one cycle after accept, q=-1, r=0, div_zero=1, ovf=0.
REQ-033 SHALL cover y=-2048, b=-1 -> q=-2048, r=0, ovf=1; y=-2048, b=-8 -> q=256, r=0, ovf=0; y=2047, b=-8 -> q=-255, r=7.
REQ-034 SHALL cover start pulsed with y=9,b=2 then start with y=50,b=5 five cycles later -> second ignored, done yields q=4, r=1.
REQ-035 SHALL cover reset_n low for one cycle mid-CALC -> all outputs 0 immediately, no done afterward; a subsequent y=20,b=4 yields q=5,r=0 after 14 cycles.

Source files
------------

// File: rtl/divider_signed.sv
// Signed restoring divider: DW-bit dividend by VW-bit divisor, truncating toward zero.
// One quotient bit per cycle on magnitudes, followed by a single sign-fix cycle.
module divider_signed #(
  parameter int DW = 12,
  parameter int VW = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [DW-1:0] y,
  input  logic [VW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
  output logic          div_zero,
  output logic          ovf
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [DW-1:0]   y_reg;
  logic [VW-1:0]   b_reg;
  logic [DW-1:0]   quo_reg;
  logic [DW:0]     rem_reg;
  logic [DW:0]     dvs_reg;

  logic            accept;
  logic            b_zero;
  logic [DW:0]     y_ext, b_ext, mag_y, mag_b;
  logic [DW:0]     trial, diff;
  logic            ge;
  logic            neg_q;
  logic [DW-1:0]   quo_signed;
  logic [VW-1:0]   rem_low, rem_signed;
  logic            min_by_neg1;

  assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign busy   = (state_reg == CALC) || (state_reg == FIX);
  assign b_zero = (b_reg == '0);

  // Magnitudes carry one extra bit so the most negative operands negate exactly.
  assign y_ext = {y_reg[DW-1], y_reg};
  assign b_ext = {{(DW + 1 - VW){b_reg[VW-1]}}, b_reg};
  assign mag_y = y_reg[DW-1] ? -y_ext : y_ext;
  assign mag_b = b_reg[VW-1] ? -b_ext : b_ext;

  assign trial = {rem_reg[DW-1:0], quo_reg[DW-1]};
  assign diff  = trial - dvs_reg;
  assign ge    = (trial >= dvs_reg);

  assign neg_q       = y_reg[DW-1] ^ b_reg[VW-1];
  assign quo_signed  = neg_q ? -quo_reg : quo_reg;
  assign rem_low     = rem_reg[VW-1:0];
  assign rem_signed  = y_reg[DW-1] ? -rem_low : rem_low;
  assign min_by_neg1 = (y_reg == {1'b1, {(DW-1){1'b0}}}) && (&b_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = CALC;
      CALC: begin
        // The first CALC cycle loads the magnitudes; a zero divisor leaves right there.
        if (cnt_reg == '0 && b_zero)
          state_next = DONE;
        else if (cnt_reg == CW'(DW))
          state_next = FIX;
      end
      FIX:  state_next = DONE;
      DONE: state_next = start ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      y_reg     <= '0;
      b_reg     <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dvs_reg   <= '0;
      done      <= 1'b0;
      q         <= '0;
      r         <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state_reg <= state_next;
      done      <= (state_next == DONE);
      if (accept) begin
        y_reg    <= y;
        b_reg    <= b;
        cnt_reg  <= '0;
        div_zero <= 1'b0;
        ovf      <= 1'b0;
      end
      case (state_reg)
        CALC: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == '0) begin
            if (b_zero) begin
              q        <= '1;
              r        <= '0;
              div_zero <= 1'b1;
            end else begin
              quo_reg <= mag_y[DW-1:0];
              dvs_reg <= mag_b;
              rem_reg <= '0;
            end
          end else begin
            rem_reg <= ge ? diff : trial;
            quo_reg <= {quo_reg[DW-2:0], ge};
          end
        end
        FIX: begin
          q   <= quo_signed;
          r   <= rem_signed;
          ovf <= min_by_neg1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_signed.sv
// Directed-vector bench for divider_signed; a queue-based scoreboard checks every done pulse.
module tb_divider_signed;

  localparam int DW = 12;
  localparam int VW = 4;
  localparam int LAT = DW + 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] y = '0;
  logic [VW-1:0] b = '0;
  logic          busy, done, div_zero, ovf;
  logic [DW-1:0] q;
  logic [VW-1:0] r;

  divider_signed #(.DW(DW), .VW(VW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .y(y), .b(b),
    .busy(busy), .done(done), .q(q), .r(r), .div_zero(div_zero), .ovf(ovf)
  );

  always #5 clock = ~clock;

  typedef struct {
    int y; int b; int q; int r; int dz; int ov; int lat; int acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clock) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn y=%0d b=%0d -> q=%0d r=%0d dz=%0d ovf=%0d lat=%0d",
                 e.y, e.b, int'($signed(q)), int'($signed(r)), div_zero, ovf, cyc - e.acc);
        chk("q", int'($signed(q)), e.q);
        chk("r", int'($signed(r)), e.r);
        chk("div_zero", int'(div_zero), e.dz);
        chk("ovf", int'(ovf), e.ov);
        chk("latency", cyc - e.acc, e.lat);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  // Caller positions at a negedge; returns just after the accepting edge.
  task automatic issue(input int yv, input int bv, input int eq, input int er,
                       input int edz, input int eov, input int elat);
    exp_t e;
    start = 1'b1;
    y = DW'(yv);
    b = VW'(bv);
    @(posedge clock);
    #1;
    start = 1'b0;
    e.y = yv; e.b = bv; e.q = eq; e.r = er; e.dz = edz; e.ov = eov; e.lat = elat; e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      chk("timeout_idle", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic wait_done_hi();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("timeout_done", 0, 1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_q", int'(q), 0);
    chk("rst_r", int'(r), 0);
    chk("rst_div_zero", int'(div_zero), 0);
    chk("rst_ovf", int'(ovf), 0);

    // Start accepted on the first edge after release
    @(negedge clock);
    reset_n = 1'b1;
    issue(-10, 5, -2, 0, 0, 0, LAT);
    chk("busy_after_accept", int'(busy), 1);
    wait_idle();

    @(negedge clock); issue(6, 3, 2, 0, 0, 0, LAT);          wait_idle();
    @(negedge clock); issue(7, -2, -3, 1, 0, 0, LAT);        wait_idle();
    @(negedge clock); issue(-7, 2, -3, -1, 0, 0, LAT);       wait_idle();
    @(negedge clock); issue(-7, -2, 3, -1, 0, 0, LAT);       wait_idle();
    @(negedge clock); issue(35, -7, -5, 0, 0, 0, LAT);       wait_idle();
    @(negedge clock); issue(100, 0, -1, 0, 1, 0, 1);         wait_idle();
    @(negedge clock); issue(-2048, -1, -2048, 0, 0, 1, LAT); wait_idle();
    @(negedge clock); issue(-2048, -8, 256, 0, 0, 0, LAT);   wait_idle();
    @(negedge clock); issue(2047, -8, -255, 7, 0, 0, LAT);   wait_idle();

    // Back-to-back: each new start lands in the done cycle of the previous one
    @(negedge clock); issue(-2048, -1, -2048, 0, 0, 1, LAT);
    wait_done_hi();   issue(100, 0, -1, 0, 1, 0, 1);
    wait_done_hi();   issue(-7, -2, 3, -1, 0, 0, LAT);
    wait_done_hi();   issue(2047, -8, -255, 7, 0, 0, LAT);
    wait_idle();

    // Start while busy is ignored
    @(negedge clock); issue(9, 2, 4, 1, 0, 0, LAT);
    repeat (4) @(negedge clock);
    start = 1'b1; y = DW'(50); b = VW'(5);
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("busy_during_ignored", int'(busy), 1);
    wait_idle();

    // Reset mid-CALC aborts the division
    @(negedge clock);
    start = 1'b1; y = DW'(9); b = VW'(2);
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_q", int'(q), 0);
    chk("abort_r", int'(r), 0);
    chk("abort_div_zero", int'(div_zero), 0);
    chk("abort_ovf", int'(ovf), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    chk("abort_idle_busy", int'(busy), 0);
    issue(20, 4, 5, 0, 0, 0, LAT);
    wait_idle();

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
